// File: rtl/mul_seq.sv
// Iterative signed multiplier for the kv10 datapath: MUL (PDP-10 double word) and IMUL.
// Shift-add on magnitudes, one multiplier bit per cycle, sign fixed up in a final cycle.
module mul_seq #(
    parameter int unsigned width = 36
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_imul,
    input  logic [width-1:0] i_a,
    input  logic [width-1:0] i_m,
    output logic             o_busy,
    output logic             o_done,
    output logic [width-1:0] o_result,
    output logic [width-1:0] o_resultlow,
    output logic             o_overflow
);

    localparam int unsigned CntW = $clog2(width);
    localparam logic [CntW-1:0] LastStep = CntW'(width - 1);
    localparam logic [width-1:0] MinWord = {1'b1, {(width - 1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } state_e;

    state_e               r_state;
    logic                 r_imul;
    logic                 r_sign;
    logic [width-1:0]     r_mag_a;
    logic [width-1:0]     r_mag_m;
    logic [2*width-1:0]   r_acc;
    logic [CntW-1:0]      r_cnt;

    logic [width-1:0]     w_abs_a;
    logic [width-1:0]     w_abs_m;
    logic [width:0]       w_sum;
    logic [2*width-1:0]   w_acc_step;
    logic [2*width-1:0]   w_prod;
    logic [width:0]       w_top;
    logic                 w_mul_ovf;
    logic [width-1:0]     w_mul_hi;
    logic [width-1:0]     w_mul_lo;
    logic                 w_imul_ovf;

    // The most negative word maps onto its own bit pattern, which is the correct unsigned magnitude.
    assign w_abs_a = i_a[width-1] ? -i_a : i_a;
    assign w_abs_m = i_m[width-1] ? -i_m : i_m;

    assign w_sum      = {1'b0, r_acc[2*width-1:width]} + {1'b0, r_mag_a};
    assign w_acc_step = r_mag_m[0] ? {w_sum, r_acc[width-1:1]}
                                   : {1'b0, r_acc[2*width-1:1]};

    assign w_prod = r_sign ? -r_acc : r_acc;

    // Only (-2^35)^2 reaches bit 70 without a matching sign bit.
    assign w_mul_ovf = w_prod[2*width-1] ^ w_prod[2*width-2];
    assign w_mul_hi  = w_mul_ovf ? MinWord : {w_prod[2*width-2:width], w_prod[width-1]};
    assign w_mul_lo  = w_mul_ovf ? MinWord : {w_prod[2*width-1], w_prod[width-2:0]};

    assign w_top      = w_prod[2*width-1:width-1];
    assign w_imul_ovf = ~((&w_top) | ~(|w_top));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_imul      <= 1'b0;
            r_sign      <= 1'b0;
            r_mag_a     <= '0;
            r_mag_m     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_result    <= '0;
            o_resultlow <= '0;
            o_overflow  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_imul  <= i_imul;
                        r_sign  <= i_a[width-1] ^ i_m[width-1];
                        r_mag_a <= w_abs_a;
                        r_mag_m <= w_abs_m;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        o_busy  <= 1'b1;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_acc   <= w_acc_step;
                    r_mag_m <= {1'b0, r_mag_m[width-1:1]};
                    r_cnt   <= r_cnt + CntW'(1);
                    if (r_cnt == LastStep) begin
                        r_state <= StFix;
                    end
                end
                StFix: begin
                    if (r_imul) begin
                        o_result    <= {width{w_prod[width-1]}};
                        o_resultlow <= w_prod[width-1:0];
                        o_overflow  <= w_imul_ovf;
                    end else begin
                        o_result    <= w_mul_hi;
                        o_resultlow <= w_mul_lo;
                        o_overflow  <= w_mul_ovf;
                    end
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: table of MUL/IMUL vectors plus busy, reset and back-to-back
// sequences.
module tb_mul_seq;

    logic        clk;
    logic        i_reset;
    logic        i_start;
    logic        i_imul;
    logic [35:0] i_a;
    logic [35:0] i_m;
    logic        o_busy;
    logic        o_done;
    logic [35:0] o_result;
    logic [35:0] o_resultlow;
    logic        o_overflow;

    int n_total = 0;
    int n_pass  = 0;

    mul_seq #(.width(36)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_imul     (i_imul),
        .i_a        (i_a),
        .i_m        (i_m),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result),
        .o_resultlow(o_resultlow),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        imul;
        logic [35:0] a;
        logic [35:0] m;
        logic [35:0] hi;
        logic [35:0] lo;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %o, expected %o", name, act, exp);
    endtask

    // Accept a start at the next edge, then count edges until done (bounded).
    task automatic run_op(input logic im, input logic [35:0] a, input logic [35:0] m,
                          input string tag, output int n);
        i_start = 1'b1;
        i_imul  = im;
        i_a     = a;
        i_m     = m;
        tick();
        i_start = 1'b0;
        check({tag, "_busy_after_start"}, {35'd0, o_busy}, 36'd1);
        n = 0;
        while (!o_done && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic check_outs(input string tag, input logic [35:0] hi, input logic [35:0] lo,
                              input logic ovf);
        check({tag, "_result"}, o_result, hi);
        check({tag, "_resultlow"}, o_resultlow, lo);
        check({tag, "_overflow"}, {35'd0, o_overflow}, {35'd0, ovf});
    endtask

    initial begin
        int n;
        int dones;
        string tag;

        vecs[0]  = '{1'b0, 36'd7, 36'd13, 36'd0, 36'o000000000133, 1'b0};
        vecs[1]  = '{1'b0, 36'o777777777776, 36'd3, 36'o777777777777, 36'o777777777772, 1'b0};
        vecs[2]  = '{1'b1, 36'o000004000000, 36'o000004000000, 36'd0, 36'd0, 1'b1};
        vecs[3]  = '{1'b0, 36'o000004000000, 36'o000004000000, 36'o000000000040, 36'd0, 1'b0};
        vecs[4]  = '{1'b0, 36'o400000000000, 36'o400000000000, 36'o400000000000,
                     36'o400000000000, 1'b1};
        vecs[5]  = '{1'b1, 36'o400000000000, 36'd1, 36'o777777777777, 36'o400000000000, 1'b0};
        vecs[6]  = '{1'b1, 36'o777777777773, 36'd7, 36'o777777777777, 36'o777777777735, 1'b0};
        vecs[7]  = '{1'b0, 36'o377777777777, 36'o377777777777, 36'o377777777776, 36'd1, 1'b0};
        vecs[8]  = '{1'b1, 36'o377777777777, 36'o377777777777, 36'd0, 36'd1, 1'b1};
        vecs[9]  = '{1'b0, 36'o777777777777, 36'o777777777777, 36'd0, 36'd1, 1'b0};
        vecs[10] = '{1'b0, 36'd0, 36'o777777777773, 36'd0, 36'd0, 1'b0};
        vecs[11] = '{1'b0, 36'o777777777771, 36'd13, 36'o777777777777, 36'o777777777645, 1'b0};

        i_reset = 1'b1;
        i_start = 1'b0;
        i_imul  = 1'b0;
        i_a     = '0;
        i_m     = '0;
        tick();
        tick();
        i_reset = 1'b0;
        check("reset_busy", {35'd0, o_busy}, 36'd0);
        check("reset_done", {35'd0, o_done}, 36'd0);
        check_outs("reset", 36'd0, 36'd0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            tag = $sformatf("vec%0d", i);
            run_op(vecs[i].imul, vecs[i].a, vecs[i].m, tag, n);
            check({tag, "_latency"}, 36'(n), 36'd37);
            check({tag, "_busy_at_done"}, {35'd0, o_busy}, 36'd0);
            check_outs(tag, vecs[i].hi, vecs[i].lo, vecs[i].ovf);
            tick();
            check({tag, "_done_one_cycle"}, {35'd0, o_done}, 36'd0);
            check_outs({tag, "_hold"}, vecs[i].hi, vecs[i].lo, vecs[i].ovf);
        end

        // Start pulse at cycle 10 and operand changes mid-run must be ignored.
        i_start = 1'b1;
        i_imul  = 1'b0;
        i_a     = 36'd7;
        i_m     = 36'd13;
        tick();
        i_start = 1'b0;
        n = 0;
        dones = 0;
        for (int e = 1; e <= 90; e++) begin
            if (e == 10) begin
                i_start = 1'b1;
                i_imul  = 1'b1;
                i_a     = 36'o123456712345;
                i_m     = 36'o765432107654;
            end else if (e == 11) begin
                i_start = 1'b0;
            end
            tick();
            if (o_done) begin
                dones++;
                if (dones == 1) begin
                    n = e;
                    check_outs("busy_ign", 36'd0, 36'o000000000133, 1'b0);
                end
            end
        end
        check("busy_ign_done_edge", 36'(n), 36'd37);
        check("busy_ign_done_count", 36'(dones), 36'd1);

        // Reset at cycle 20 abandons the op; start with reset in the same cycle is refused.
        i_start = 1'b1;
        i_imul  = 1'b0;
        i_a     = 36'o777777777776;
        i_m     = 36'd3;
        tick();
        i_start = 1'b0;
        for (int e = 1; e < 20; e++) tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("midreset_busy", {35'd0, o_busy}, 36'd0);
        check("midreset_done", {35'd0, o_done}, 36'd0);
        check_outs("midreset", 36'd0, 36'd0, 1'b0);
        i_reset = 1'b1;
        i_start = 1'b1;
        tick();
        i_reset = 1'b0;
        i_start = 1'b0;
        check("reset_beats_start", {35'd0, o_busy}, 36'd0);
        dones = 0;
        for (int e = 0; e < 50; e++) begin
            tick();
            if (o_done) dones++;
        end
        check("midreset_no_done", 36'(dones), 36'd0);
        run_op(1'b0, 36'o777777777776, 36'd3, "after_reset", n);
        check("after_reset_latency", 36'(n), 36'd37);
        check_outs("after_reset", 36'o777777777777, 36'o777777777772, 1'b0);
        tick();

        // Back-to-back with start held high: second op is accepted at edge 38.
        i_start = 1'b1;
        i_imul  = 1'b0;
        i_a     = 36'd7;
        i_m     = 36'd13;
        tick();
        i_imul  = 1'b1;
        i_a     = 36'o777777777773;
        i_m     = 36'd7;
        dones = 0;
        for (int e = 1; e <= 85; e++) begin
            tick();
            if (e == 75) i_start = 1'b0;
            if (o_done) begin
                dones++;
                if (dones == 1) begin
                    check("b2b_first_edge", 36'(e), 36'd37);
                    check_outs("b2b_first", 36'd0, 36'o000000000133, 1'b0);
                end else if (dones == 2) begin
                    check("b2b_second_edge", 36'(e), 36'd75);
                    check_outs("b2b_second", 36'o777777777777, 36'o777777777735, 1'b0);
                end
            end
        end
        check("b2b_done_count", 36'(dones), 36'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
